// File: rtl/riscv_pipe_pkg.sv
// Shared types for the pipeline register chain: decoded control payload and default depth.
// No logic; popcount helper used for occupancy and squash accounting.
// Payload layout matches the controller/decoder outputs that feed EX/MEM.
package riscv_pipe_pkg;

    localparam int PIPE_DEPTH_DEFAULT = 3;

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } pipe_ctrl_t;

    // Stage masks are at most 64 bits wide; callers zero-extend into this argument.
    function automatic int unsigned popcount(input logic [63:0] bits);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += int'(bits[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/riscv_pipe_chain_if.sv
// Handshake, flush and status bundle between upstream/downstream logic and the pipe chain.
// master = surrounding core (or bench), slave = the chain itself.
// Back-pressure travels on out_ready -> in_ready inside the chain.
interface riscv_pipe_chain_if
    import riscv_pipe_pkg::*;
#(
    parameter int DEPTH = PIPE_DEPTH_DEFAULT,
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) ();

    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH-1:0]           in_data;
    logic                       in_kill;
    logic [DEPTH-1:0]           flush_mask;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           out_data;
    logic [$clog2(DEPTH+1)-1:0] occupancy;
    logic [CNT_W-1:0]           stall_cnt;
    logic [CNT_W-1:0]           flush_cnt;

    modport master (
        output in_valid, in_data, in_kill, flush_mask, out_ready,
        input  in_ready, out_valid, out_data, occupancy, stall_cnt, flush_cnt
    );

    modport slave (
        input  in_valid, in_data, in_kill, flush_mask, out_ready,
        output in_ready, out_valid, out_data, occupancy, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/riscv_pipe_slot.sv
// One pipeline stage: valid bit plus payload register with load / hold / squash.
// Latency 1 cycle from load to v; data holds whenever load is low.
// No back-pressure of its own: the parent decides load and keep.
module riscv_pipe_slot
    import riscv_pipe_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             keep,
    input  logic [WIDTH-1:0] din,
    output logic             v,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
            q <= '0;
        end else begin
            v <= load | keep;
            if (load) begin
                q <= din;
            end
        end
    end

endmodule

// File: rtl/riscv_pipe_chain.sv
// In-order DEPTH-stage register chain with per-stage squash; optional counters under PIPE_PERF_EN.
// Latency DEPTH cycles on an empty chain, 1 entry/cycle throughput.
// Back-pressure: in_ready is a combinational ripple from out_ready through every stage.
module riscv_pipe_chain
    import riscv_pipe_pkg::*;
#(
    parameter int DEPTH = PIPE_DEPTH_DEFAULT,
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    riscv_pipe_chain_if.slave bus
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] move;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] keep;
    logic [DEPTH-1:0] v_next;
    logic [WIDTH-1:0] data [DEPTH];
    logic             chain_rdy;
    logic [OCC_W-1:0] occ_q;

    // A squashed occupant is treated as empty in the very cycle it is squashed.
    assign live = v & ~bus.flush_mask;

    always_comb begin
        chain_rdy = bus.out_ready;
        move      = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            move[i]   = live[i] & chain_rdy;
            chain_rdy = ~live[i] | move[i];
        end
    end

    always_comb begin
        load    = '0;
        load[0] = bus.in_valid & chain_rdy & ~bus.in_kill;
        for (int i = 1; i < DEPTH; i++) begin
            load[i] = move[i-1];
        end
    end

    assign keep   = live & ~move;
    assign v_next = load | keep;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            riscv_pipe_slot #(.WIDTH(WIDTH)) u_slot (
                .clk  (clk),
                .rst  (rst),
                .load (load[g]),
                .keep (keep[g]),
                .din  (bus.in_data),
                .v    (v[g]),
                .q    (data[g])
            );
        end else begin : g_body
            riscv_pipe_slot #(.WIDTH(WIDTH)) u_slot (
                .clk  (clk),
                .rst  (rst),
                .load (load[g]),
                .keep (keep[g]),
                .din  (data[g-1]),
                .v    (v[g]),
                .q    (data[g])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= OCC_W'(popcount(64'(v_next)));
        end
    end

    assign bus.in_ready  = chain_rdy;
    assign bus.out_valid = live[DEPTH-1];
    assign bus.out_data  = data[DEPTH-1];
    assign bus.occupancy = occ_q;

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (live[DEPTH-1] & ~bus.out_ready) begin
                stall_q <= stall_q + 1'b1;
            end
            flush_q <= flush_q + CNT_W'(popcount(64'(v & bus.flush_mask)));
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_riscv_pipe_chain.sv
// Directed bench for riscv_pipe_chain (DEPTH=3): throughput, stall, squash, kill and reset.
// Counter expectations follow whether PIPE_PERF_EN is defined for the build.
module tb_riscv_pipe_chain;

    localparam int DEPTH = 3;
    localparam int WIDTH = 64;
    localparam int CNT_W = 32;

`ifdef PIPE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    riscv_pipe_chain_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    riscv_pipe_chain #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Kill scenario: beat 0x20, killed 0xDEAD, beat 0x21, then idle.
    int          t5_vin  [7] = '{1, 1, 1, 0, 0, 0, 0};
    int          t5_kill [7] = '{0, 1, 0, 0, 0, 0, 0};
    logic [63:0] t5_din  [7] = '{64'h20, 64'hDEAD, 64'h21, 64'h0, 64'h0, 64'h0, 64'h0};
    int          t5_ov   [7] = '{0, 0, 0, 1, 0, 1, 0};
    logic [63:0] t5_od   [7] = '{64'd13, 64'd13, 64'd13, 64'h20, 64'h20, 64'h21, 64'h21};
    int          t5_occ  [7] = '{0, 1, 1, 2, 1, 1, 0};

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_kill    = 1'b0;
        bus.flush_mask = '0;
        bus.out_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        @(negedge clk);
        check_eq("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_out_data",  bus.out_data,       64'd0);
        check_eq("rst_occ",       64'(bus.occupancy), 64'd0);
        check_eq("rst_stall",     64'(bus.stall_cnt), 64'd0);
        check_eq("rst_flush",     64'(bus.flush_cnt), 64'd0);
        tick();

        // Streaming: accepted at cycle c, seen at c+3.
        for (int c = 0; c < 6; c++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = 64'(c + 1);
            bus.out_ready = 1'b1;
            @(negedge clk);
            check_eq("t1_in_ready",  64'(bus.in_ready),  64'd1);
            check_eq("t1_out_valid", 64'(bus.out_valid), (c >= 3) ? 64'd1 : 64'd0);
            if (c >= 3) begin
                check_eq("t1_out_data", bus.out_data, 64'(c - 2));
            end
            tick();
        end

        // Chain holds 4 (out), 5, 6. Stall for 5 cycles.
        for (int c = 0; c < 5; c++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = 64'd7;
            bus.out_ready = 1'b0;
            @(negedge clk);
            check_eq("t2_in_ready",  64'(bus.in_ready),  64'd0);
            check_eq("t2_out_valid", 64'(bus.out_valid), 64'd1);
            check_eq("t2_out_data",  bus.out_data,       64'd4);
            check_eq("t2_occ",       64'(bus.occupancy), 64'd3);
            tick();
        end

        // Squash stages 0 and 1 (6 and 5) while the output stays stalled.
        bus.in_valid   = 1'b0;
        bus.flush_mask = 3'b011;
        @(negedge clk);
        check_eq("t2_stall_cnt",  64'(bus.stall_cnt), PERF ? 64'd5 : 64'd0);
        check_eq("t3_in_ready",   64'(bus.in_ready),  64'd1);
        check_eq("t3_out_valid",  64'(bus.out_valid), 64'd1);
        check_eq("t3_out_data",   bus.out_data,       64'd4);
        tick();
        bus.flush_mask = '0;
        bus.out_ready  = 1'b1;
        @(negedge clk);
        check_eq("t3_occ",        64'(bus.occupancy), 64'd1);
        check_eq("t3_flush_cnt",  64'(bus.flush_cnt), PERF ? 64'd2 : 64'd0);
        check_eq("t3_stall_cnt",  64'(bus.stall_cnt), PERF ? 64'd6 : 64'd0);
        check_eq("t3_out_valid2", 64'(bus.out_valid), 64'd1);
        check_eq("t3_out_data2",  bus.out_data,       64'd4);
        tick();
        @(negedge clk);
        check_eq("t3_drained",    64'(bus.out_valid), 64'd0);
        check_eq("t3_occ_empty",  64'(bus.occupancy), 64'd0);
        check_eq("t3_data_hold",  bus.out_data,       64'd4);
        tick();

        // Fill with 10,11,12 under stall, then squash the output stage while loading 13.
        for (int j = 0; j < 3; j++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = 64'(10 + j);
            bus.out_ready = 1'b0;
            @(negedge clk);
            check_eq("t4_fill_rdy",   64'(bus.in_ready),  64'd1);
            check_eq("t4_fill_ov",    64'(bus.out_valid), 64'd0);
            tick();
        end
        bus.in_data    = 64'd13;
        bus.out_ready  = 1'b1;
        bus.flush_mask = 3'b100;
        @(negedge clk);
        check_eq("t4_in_ready",  64'(bus.in_ready),  64'd1);
        check_eq("t4_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("t4_occ",       64'(bus.occupancy), 64'd3);
        tick();
        bus.in_valid   = 1'b0;
        bus.flush_mask = '0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_eq("t4_ov",   64'(bus.out_valid), 64'd1);
            check_eq("t4_data", bus.out_data,       64'(11 + j));
            tick();
        end
        @(negedge clk);
        check_eq("t4_empty",     64'(bus.out_valid), 64'd0);
        check_eq("t4_occ_empty", 64'(bus.occupancy), 64'd0);
        check_eq("t4_flush_cnt", 64'(bus.flush_cnt), PERF ? 64'd3 : 64'd0);
        check_eq("t4_stall_cnt", 64'(bus.stall_cnt), PERF ? 64'd6 : 64'd0);
        tick();

        // Killed beat completes the handshake but leaves a bubble.
        for (int k = 0; k < 7; k++) begin
            bus.in_valid  = t5_vin[k][0];
            bus.in_kill   = t5_kill[k][0];
            bus.in_data   = t5_din[k];
            bus.out_ready = 1'b1;
            @(negedge clk);
            check_eq("t5_in_ready",  64'(bus.in_ready),  64'd1);
            check_eq("t5_out_valid", 64'(bus.out_valid), 64'(t5_ov[k]));
            check_eq("t5_out_data",  bus.out_data,       t5_od[k]);
            check_eq("t5_occ",       64'(bus.occupancy), 64'(t5_occ[k]));
            tick();
        end
        bus.in_kill = 1'b0;

        // Two live entries, then reset while a third beat is offered.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        bus.in_data   = 64'h30;
        tick();
        bus.in_data   = 64'h31;
        tick();
        bus.in_data   = 64'h32;
        @(negedge clk);
        check_eq("t6_occ_pre", 64'(bus.occupancy), 64'd2);
        rst = 1'b1;
        tick();
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq("t6_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("t6_occ",       64'(bus.occupancy), 64'd0);
        check_eq("t6_out_data",  bus.out_data,       64'd0);
        check_eq("t6_stall",     64'(bus.stall_cnt), 64'd0);
        check_eq("t6_flush",     64'(bus.flush_cnt), 64'd0);
        check_eq("t6_in_ready",  64'(bus.in_ready),  64'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            check_eq("t6_lost", 64'(bus.out_valid), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
